// File: rtl/ptw_pkg.sv
// Shared types and helpers for the PTW memory responder: FSM states,
// Err_flags bit positions and the line-offset derivation.
package ptw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ptw_state_e;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_OVERLAP  = 1;
  localparam int ERR_TIMEOUT  = 2;

  // Number of byte-offset bits inside one main-memory line.
  function automatic int line_off(input int line_bits);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) == (line_bits / 8)) begin
        n = i;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/ptw_mem_responder_if.sv
// PTE word interface (PTW side) and main-memory line port bundled together;
// slave is the responder's view, master is the PTW/memory environment's view.
interface ptw_mem_responder_if #(
  parameter int PC_BITS   = 20,
  parameter int LINE_BITS = 128
);
  logic                 Ptw_mem_req;
  logic [PC_BITS-1:0]   Ptw_mem_addr;
  logic [31:0]          Ptw_mem_rdata;
  logic                 Ptw_mem_valid;
  logic                 Pmem_req;
  logic [PC_BITS-1:0]   Pmem_addr;
  logic [LINE_BITS-1:0] Pmem_rdata;
  logic                 Pmem_valid;

  modport slave (
    input  Ptw_mem_req, Ptw_mem_addr, Pmem_rdata, Pmem_valid,
    output Ptw_mem_rdata, Ptw_mem_valid, Pmem_req, Pmem_addr
  );

  modport master (
    output Ptw_mem_req, Ptw_mem_addr, Pmem_rdata, Pmem_valid,
    input  Ptw_mem_rdata, Ptw_mem_valid, Pmem_req, Pmem_addr
  );
endinterface

// File: rtl/ptw_pte_line_cache.sv
// Single-entry PTE line cache: one valid bit, one line tag, one line.
// A flush always wins over a simultaneous fill.
module ptw_pte_line_cache #(
  parameter int TAG_BITS  = 16,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fill,
  input  logic [TAG_BITS-1:0]  fill_tag,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic [TAG_BITS-1:0]  look_tag,
  output logic                 hit,
  output logic [LINE_BITS-1:0] line
);
  logic                 valid_r;
  logic [TAG_BITS-1:0]  tag_r;
  logic [LINE_BITS-1:0] line_r;

  // Entry storage: valid tracks flush/fill, tag and data load on fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      line_r  <= '0;
    end else begin
      if (flush) begin
        valid_r <= 1'b0;
      end else if (fill) begin
        valid_r <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (fill) begin
        tag_r  <= fill_tag;
        line_r <= fill_line;
      end else begin
        tag_r  <= tag_r;
        line_r <= line_r;
      end
    end
  end

  assign hit  = valid_r && (tag_r == look_tag);
  assign line = line_r;
endmodule

// File: rtl/ptw_mem_responder.sv
// PTW memory responder: reads a PTE word via the shared line port, arbitrating
// against the dcache. Define PTW_RESP_PTE_CACHE_EN for the one-line PTE cache.
module ptw_mem_responder
  import ptw_pkg::*;
#(
  parameter int PC_BITS   = 20,
  parameter int LINE_BITS = 128,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  ptw_mem_responder_if.slave  bus,
  input  logic                Dc_mem_busy,
  output logic                Ptw_owns_mem,
  input  logic                Pte_flush,
  output logic [2:0]          Err_flags
);
  localparam int OFF = line_off(LINE_BITS);
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  ptw_state_e          state_r, state_s;
  logic [PC_BITS-1:2]  addr_r, addr_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                hit_pend_r, hit_pend_s;
  logic [31:0]         rdata_r, rdata_s;
  logic                valid_r, valid_s;
  logic                pmem_req_r, pmem_req_s;
  logic [PC_BITS-1:0]  pmem_addr_r, pmem_addr_s;
  logic [2:0]          err_r, err_s;
  logic                fill_s;
  logic                hit_s;
  logic [LINE_BITS-1:0] cache_line_s;
  logic [OFF-3:0]      idx_s;

  assign idx_s = addr_r[OFF-1:2];

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    cnt_s       = cnt_r;
    hit_pend_s  = hit_pend_r;
    rdata_s     = rdata_r;
    valid_s     = 1'b0;
    pmem_req_s  = 1'b0;
    pmem_addr_s = pmem_addr_r;
    err_s       = err_r;
    fill_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.Ptw_mem_req) begin
          addr_s  = bus.Ptw_mem_addr[PC_BITS-1:2];
          state_s = ISSUE;
          if (bus.Ptw_mem_addr[1:0] != 2'b00) begin
            err_s[ERR_MISALIGN] = 1'b1;
          end else begin
            err_s[ERR_MISALIGN] = err_r[ERR_MISALIGN];
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // A cache hit bypasses arbitration; the dcache keeps the port.
        if (hit_s) begin
          hit_pend_s = 1'b1;
          state_s    = WAIT;
        end else if (!Dc_mem_busy) begin
          pmem_req_s  = 1'b1;
          pmem_addr_s = {addr_r[PC_BITS-1:OFF], {OFF{1'b0}}};
          cnt_s       = '0;
          state_s     = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (hit_pend_r) begin
          rdata_s    = cache_line_s[{idx_s, 5'b00000} +: 32];
          valid_s    = 1'b1;
          hit_pend_s = 1'b0;
          state_s    = IDLE;
        end else if (bus.Pmem_valid) begin
          rdata_s = bus.Pmem_rdata[{idx_s, 5'b00000} +: 32];
          valid_s = 1'b1;
          fill_s  = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          rdata_s            = 32'h0000_0000;
          valid_s            = 1'b1;
          err_s[ERR_TIMEOUT] = 1'b1;
          state_s            = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (bus.Ptw_mem_req && (state_r != IDLE)) begin
      err_s[ERR_OVERLAP] = 1'b1;
    end else begin
      err_s[ERR_OVERLAP] = err_s[ERR_OVERLAP];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      cnt_r       <= '0;
      hit_pend_r  <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      valid_r     <= 1'b0;
      pmem_req_r  <= 1'b0;
      pmem_addr_r <= '0;
      err_r       <= 3'b000;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      cnt_r       <= cnt_s;
      hit_pend_r  <= hit_pend_s;
      rdata_r     <= rdata_s;
      valid_r     <= valid_s;
      pmem_req_r  <= pmem_req_s;
      pmem_addr_r <= pmem_addr_s;
      err_r       <= err_s;
    end
  end

  assign bus.Ptw_mem_rdata = rdata_r;
  assign bus.Ptw_mem_valid = valid_r;
  assign bus.Pmem_req      = pmem_req_r;
  assign bus.Pmem_addr     = pmem_addr_r;
  assign Err_flags         = err_r;
  assign Ptw_owns_mem      = ((state_r == ISSUE) && !Dc_mem_busy && !hit_s) ||
                             ((state_r == WAIT) && !hit_pend_r);

`ifdef PTW_RESP_PTE_CACHE_EN
  ptw_pte_line_cache #(
    .TAG_BITS (PC_BITS - OFF),
    .LINE_BITS(LINE_BITS)
  ) u_cache (
    .clk      (clk),
    .rst      (rst),
    .flush    (Pte_flush),
    .fill     (fill_s),
    .fill_tag (addr_r[PC_BITS-1:OFF]),
    .fill_line(bus.Pmem_rdata),
    .look_tag (addr_r[PC_BITS-1:OFF]),
    .hit      (hit_s),
    .line     (cache_line_s)
  );
`else
  logic unused_s;
  assign hit_s        = 1'b0;
  assign cache_line_s = '0;
  assign unused_s     = ^{Pte_flush, fill_s};
`endif
endmodule
